// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch unit and its
//               circular fetch queue.
//               Contents:
//                 XLEN       - machine word width
//                 NOP        - instruction shown on an invalid output slot
//                 fq_entry_t - one queue entry {pc, inst}
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Dual-enqueue / dual-dequeue circular buffer with flush.
//               Owns the head and tail pointers and the occupancy count.
//               Ports:
//                 clk, rst   - clock and synchronous active-high reset
//                 flush      - empties the queue; the dequeue request is ignored
//                 enq        - write two entries at tail and tail+1
//                 wr_data[1:0] - entries to write ([0] goes to tail)
//                 take       - number of head entries consumed (0..3, clamped)
//                 rd_data[1:0] - entries at head and head+1 (raw storage)
//                 count      - occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq,
  input  fq_entry_t [1:0]            wr_data,
  input  logic      [1:0]            take,
  output fq_entry_t [1:0]            rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t          r_mem [DEPTH];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic [1:0]         w_avail;
  logic [1:0]         w_take_c;
  logic [PW-1:0]      w_head_p1;
  logic [PW-1:0]      w_tail_p1;

  // Pointer arithmetic wraps naturally because the pointers are exactly
  // log2(DEPTH) bits wide.
  assign w_head_p1 = r_head + PW'(1);
  assign w_tail_p1 = r_tail + PW'(1);

  // Decode can never take more than the slots currently presented.
  always_comb begin
    w_avail  = (r_count > CW'(1)) ? 2'd2 : r_count[1:0];
    w_take_c = (take > w_avail) ? w_avail : take;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_take_c);
      r_tail  <= enq ? (r_tail + PW'(2)) : r_tail;
      r_count <= r_count + (enq ? CW'(2) : CW'(0)) - CW'(w_take_c);
    end
  end

  // Storage is not reset; validity comes solely from the count.
  always_ff @(posedge clk) begin
    if (enq) begin
      r_mem[r_tail]    <= wr_data[0];
      r_mem[w_tail_p1] <= wr_data[1];
    end
  end

  assign rd_data[0] = r_mem[r_head];
  assign rd_data[1] = r_mem[w_head_p1];
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetch-side initiator for a dual-issue instruction memory.
//               Drives the fetch PC, captures the two returned words into a
//               circular fetch queue and presents up to two in-order
//               instructions to decode. Redirects flush the queue and reload
//               the PC.
//               Ports:
//                 clk, rst        - clock and synchronous active-high reset
//                 pc_fetch        - registered fetch address
//                 inst_in[1:0]    - words at pc_fetch and pc_fetch+4
//                 redirect_valid  - flush and reload request
//                 redirect_pc     - new fetch target (word aligned internally)
//                 dec_take        - entries consumed by decode this cycle
//                 out_valid[1:0]  - slot valid flags
//                 out_inst[1:0]   - slot instructions (NOP when invalid)
//                 out_pc[1:0]     - slot PCs
//                 fq_count        - occupied queue entries
//                 full_cycles     - saturating count of fetch-blocked cycles
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               QDepth  = 8,
  parameter logic [XLEN-1:0]  ResetPC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [XLEN-1:0]              pc_fetch,
  input  logic [1:0][XLEN-1:0]         inst_in,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  input  logic [1:0]                   dec_take,
  output logic [1:0]                   out_valid,
  output logic [1:0][XLEN-1:0]         out_inst,
  output logic [1:0][XLEN-1:0]         out_pc,
  output logic [$clog2(QDepth):0]      fq_count,
  output logic [XLEN-1:0]              full_cycles
);

  localparam int CW = $clog2(QDepth) + 1;
  // Enqueue needs two free slots, i.e. count <= QDepth-2.
  localparam logic [CW-1:0] C_ENQ_LIMIT = CW'(QDepth - 2);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_full_cycles;
  logic             w_enq;
  logic [XLEN-1:0]  w_redirect_target;
  fq_entry_t [1:0]  w_wr_data;
  fq_entry_t [1:0]  w_rd_data;
  logic [CW-1:0]    w_count;

  // Decision uses only the registered count, so there is no path from
  // dec_take to the memory address.
  assign w_enq             = !redirect_valid && (w_count <= C_ENQ_LIMIT);
  assign w_redirect_target = redirect_pc & ~32'h0000_0003;

  assign w_wr_data[0] = '{pc: r_pc,            inst: inst_in[0]};
  assign w_wr_data[1] = '{pc: r_pc + 32'd4,    inst: inst_in[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= ResetPC;
      r_full_cycles <= '0;
    end else begin
      if (redirect_valid) begin
        r_pc <= w_redirect_target;
      end else if (w_enq) begin
        r_pc <= r_pc + 32'd8;
      end
      if (!w_enq && (r_full_cycles != '1)) begin
        r_full_cycles <= r_full_cycles + 32'd1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDepth)
  ) u_fetch_queue (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .enq     (w_enq),
    .wr_data (w_wr_data),
    .take    (dec_take),
    .rd_data (w_rd_data),
    .count   (w_count)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign out_valid[gi] = (w_count > CW'(gi));
    assign out_inst[gi]  = out_valid[gi] ? w_rd_data[gi].inst : NOP;
    assign out_pc[gi]    = w_rd_data[gi].pc;
  end

  assign pc_fetch    = r_pc;
  assign fq_count    = w_count;
  assign full_cycles = r_full_cycles;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A memory model answers
//               fetches; expected PC order is queued by the stimulus and a
//               monitor pops and compares every slot that decode consumes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int QD = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      pc_fetch;
  logic [1:0][31:0] inst_in;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [1:0]       dec_take;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][31:0] out_pc;
  logic [3:0]       fq_count;
  logic [31:0]      full_cycles;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.QDepth(QD), .ResetPC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_fetch(pc_fetch), .inst_in(inst_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_take(dec_take), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .fq_count(fq_count), .full_cycles(full_cycles)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  always_comb begin
    inst_in[0] = memw(pc_fetch);
    inst_in[1] = memw(pc_fetch + 32'd4);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every slot decode takes must be the next expected PC.
  always @(negedge clk) begin
    if (rst === 1'b0 && redirect_valid === 1'b0) begin
      if (out_valid[1] && !out_valid[0]) begin
        checks++; errors++;
        $display("FAIL valid_order: got %b expected slot1 only with slot0", out_valid);
      end
      for (int i = 0; i < 2; i++) begin
        if (int'(dec_take) > i && out_valid[i]) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got pc %h expected nothing", out_pc[i]);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("out_pc", out_pc[i], e);
            check("out_inst", out_inst[i], memw(e));
            consumed++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_take = 2'd0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    consumed = 0;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  initial begin
    int exp_cnt3 [8] = '{2, 3, 4, 5, 6, 7, 6, 7};
    int pat [4] = '{1, 2, 0, 2};
    int cyc;

    // Reset values and fill with no decode.
    do_reset();
    check("rst_out_valid", {30'd0, out_valid}, 32'd0);
    check("rst_fq_count", {28'd0, fq_count}, 32'd0);
    check("rst_pc", pc_fetch, 32'h0);
    check("rst_full", full_cycles, 32'd0);
    check("rst_nop", out_inst[0], NOP);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("fill_pc", pc_fetch, 32'(8 * k));
      check("fill_cnt", {28'd0, fq_count}, 32'(2 * k));
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      check("stall_pc", pc_fetch, 32'h20);
      check("stall_full", full_cycles, 32'(k));
      check("stall_valid", {30'd0, out_valid}, 32'd3);
    end

    // Steady dual take; first cycle requests 2 while nothing is valid.
    do_reset();
    push_seq(32'h0, 40);
    dec_take = 2'd2;
    tick();
    check("take2_first_cnt", {28'd0, fq_count}, 32'd2);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("take2_cnt", {28'd0, fq_count}, 32'd2);
    end
    check("take2_full", full_cycles, 32'd0);
    check("take2_consumed", 32'(consumed), 32'd20);

    // Single take: occupancy climbs, fetch stalls when fewer than 2 free.
    do_reset();
    push_seq(32'h0, 40);
    dec_take = 2'd1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("take1_cnt", {28'd0, fq_count}, 32'(exp_cnt3[k]));
    end
    check("take1_pc", pc_fetch, 32'h38);
    check("take1_full", full_cycles, 32'd1);
    dec_take = 2'd2;  // at 7 entries no enqueue, two taken
    tick();
    check("take1_drain_cnt", {28'd0, fq_count}, 32'd5);
    dec_take = 2'd0;

    // Redirect at 6 entries with a misaligned target.
    do_reset();
    repeat (3) tick();
    check("pre_redir_cnt", {28'd0, fq_count}, 32'd6);
    redirect_valid = 1'b1; redirect_pc = 32'h107; dec_take = 2'd2;
    exp_q.delete();
    push_seq(32'h104, 20);
    tick();
    check("redir_cnt", {28'd0, fq_count}, 32'd0);
    check("redir_valid", {30'd0, out_valid}, 32'd0);
    check("redir_pc", pc_fetch, 32'h104);
    redirect_valid = 1'b0; dec_take = 2'd0;
    tick();
    check("redir_valid2", {30'd0, out_valid}, 32'd3);
    check("redir_out_pc0", out_pc[0], 32'h104);
    check("redir_out_pc1", out_pc[1], 32'h108);
    check("redir_out_inst0", out_inst[0], memw(32'h104));
    check("redir_out_inst1", out_inst[1], memw(32'h108));
    consumed = 0;
    dec_take = 2'd2;
    repeat (3) tick();
    dec_take = 2'd0;
    check("redir_consumed", 32'(consumed), 32'd6);

    // Pointer wrap with a mixed take pattern.
    do_reset();
    push_seq(32'h0, 64);
    cyc = 0;
    while (cyc < 200 && consumed < 40) begin
      dec_take = 2'(pat[cyc % 4]);
      tick();
      cyc++;
    end
    dec_take = 2'd0;
    check("wrap_progress", {31'd0, consumed >= 40}, 32'd1);

    // PC wrap at the top of the address space.
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    push_seq(32'hFFFF_FFF8, 16);
    tick();
    check("top_pc", pc_fetch, 32'hFFFF_FFF8);
    redirect_valid = 1'b0;
    tick();
    check("wrap_pc", pc_fetch, 32'h0);
    check("wrap_out_pc0", out_pc[0], 32'hFFFF_FFF8);
    check("wrap_out_pc1", out_pc[1], 32'hFFFF_FFFC);
    tick();
    check("wrap_pc2", pc_fetch, 32'h8);
    check("wrap_cnt", {28'd0, fq_count}, 32'd4);
    consumed = 0;
    dec_take = 2'd2;
    repeat (2) tick();
    dec_take = 2'd0;
    check("wrap_consumed", 32'(consumed), 32'd4);

    // Reset dominates a simultaneous redirect.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    tick();
    check("rst_redir_pc", pc_fetch, 32'h0);
    check("rst_redir_cnt", {28'd0, fq_count}, 32'd0);
    check("rst_redir_valid", {30'd0, out_valid}, 32'd0);
    rst = 1'b0; redirect_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
